// File: rtl/rca_pkg.sv
// Shared types and constants for the sequential ripple-carry adder controller.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rca_state_e;

    localparam int unsigned SLICE_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_slice.sv
// Slice-wide ripple-carry adder built from full_adder cells.
module rca_slice #(
    parameter int unsigned SliceW = 4
) (
    input  logic [SliceW-1:0] a_i,
    input  logic [SliceW-1:0] b_i,
    input  logic              c_i,
    output logic [SliceW-1:0] s_o,
    output logic              c_o,
    output logic              c_msb_o
);

    logic [SliceW:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < SliceW; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (s_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign c_o     = carry[SliceW];
    // Carry into the top bit; XOR with c_o gives signed overflow.
    assign c_msb_o = carry[SliceW-1];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequential adder: one shared rca_slice processes WIDTH/SLICE slices, LSB first.
// Define RCA_SUB_EN to add the sub port (a-b via inverted B and carry-in of 1).
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef RCA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned NSlices = WIDTH / SLICE;
    localparam int unsigned IdxW    = (NSlices > 1) ? $clog2(NSlices) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NSlices - 1);

    if (SLICE == 0 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("rca_seq_ctrl: WIDTH must be a non-zero multiple of SLICE");
    end

    rca_state_e       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef RCA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : carry_in;
`else
    assign b_eff   = b;
    assign cin_eff = carry_in;
`endif

    logic [SLICE-1:0] slice_a, slice_b, slice_s;
    logic             slice_c, slice_c_msb;

    assign slice_a = a_q[idx_q*SLICE +: SLICE];
    assign slice_b = b_q[idx_q*SLICE +: SLICE];

    rca_slice #(
        .SliceW (SLICE)
    ) u_slice (
        .a_i     (slice_a),
        .b_i     (slice_b),
        .c_i     (carry_q),
        .s_o     (slice_s),
        .c_o     (slice_c),
        .c_msb_o (slice_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE +: SLICE] = slice_s;
                carry_d = slice_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d  = slice_c;
                    ovf_d   = slice_c_msb ^ slice_c;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl at WIDTH=16, SLICE=4.
module tb_rca_seq_ctrl;

    localparam int unsigned W   = 16;
    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, carry_in, sub_i;
    logic [W-1:0] a, b, sum;
    logic         out_valid, out_ready, carry_out, ovf, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(
        .WIDTH (16),
        .SLICE (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef RCA_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                         input logic msub, output logic [W-1:0] ms, output logic mco,
                         output logic mov);
        int unsigned u;
        int sa, sb, sg;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            u  = int'(ma) + int'(~mb) + 1;
            sg = sa - sb;
        end else begin
            u  = int'(ma) + int'(mb) + int'(mcin);
            sg = sa + sb + int'(mcin);
        end
        ms  = u[W-1:0];
        mco = u[W];
        mov = (sg > 32767) || (sg < -32768);
    endtask

    // Present operands at a negedge while IDLE; returns right after the accepting edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                            input logic tsub);
        a        = ta;
        b        = tb;
        carry_in = tcin;
        sub_i    = tsub;
        in_valid = 1'b1;
        check("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] es, input logic eco,
                               input logic eov);
        int lat = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid || lat >= 20) break;
            check({name, "_busy_run"}, {30'd0, busy, in_ready}, 32'b10);
            @(posedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(LAT));
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(carry_out), 32'(eco));
        check({name, "_ovf"}, 32'(ovf), 32'(eov));
    endtask

    task automatic release_op(input string name, input logic [W-1:0] es, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_sum"}, {14'd0, out_valid, in_ready, sum}, {16'h0002, es});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_back_idle"}, {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, rs, eco, eov;
        int           stuck;

        vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b0};
        vecs[1] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, s: 16'h5556, co: 1'b0, ov: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0, ov: 1'b1};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, cin: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b1};
        vecs[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, co: 1'b1, ov: 1'b0};
        vecs[5] = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, s: 16'h1000, co: 1'b0, ov: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub_i     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", {29'd0, in_ready, out_valid, busy}, 32'b100);

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            wait_result($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, vecs[i].ov);
            release_op($sformatf("vec%0d", i), vecs[i].s, 0);
        end

        // Result held under back-pressure while new operands are offered.
        start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_result("hold1", 16'h5556, 1'b0, 1'b0);
        a        = 16'h7FFF;
        b        = 16'h0001;
        carry_in = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_sum", 32'(sum), 32'h5556);
            check("hold_flags", {29'd0, out_valid, in_ready, busy}, 32'b101);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_idle_gap", {30'd0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        wait_result("hold2", 16'h8000, 1'b0, 1'b1);
        release_op("hold2", 16'h8000, 0);

        // Reset sampled on the edge ending the 2nd RUN cycle.
        start_op(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);
        stuck = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) stuck++;
        end
        check("rst_no_out_valid", 32'(stuck), 32'd0);

`ifdef RCA_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_result("sub_5_7", 16'hFFFE, 1'b0, 1'b0);
        release_op("sub_5_7", 16'hFFFE, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef RCA_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            model(ra, rb, rc, rs, es, eco, eov);
            start_op(ra, rb, rc, rs);
            wait_result($sformatf("rnd%0d", i), es, eco, eov);
            release_op($sformatf("rnd%0d", i), es, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
